// File: rtl/uart_buffered_tx.sv
// Buffered 9-bit UART transmitter: valid/ready push into a FIFO, then start + 9 data bits LSB first + stop.
// Define UART_TX_PARITY_EN to insert an even parity bit between data bit 8 and the stop bit.
module uart_buffered_tx #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [8:0]                    data,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_CLKS = CLK_HZ / BAUD_RATE;
  localparam int TW       = $clog2(BIT_CLKS) + 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic push, pop, timer_done;

  assign data_ready = count_q < DEPTH_C;
  assign push       = data_valid && data_ready;
  assign timer_done = timer_q == TIMER_LAST;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != S_IDLE) begin
      timer_d = timer_done ? '0 : timer_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_done) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 4'd8) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (timer_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (timer_done) begin
          // Chain straight into the next frame so bursts leave no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end
  end

  // The line level is derived from the next state so tx stays a plain register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Scoreboard bench for uart_buffered_tx: pushed words are queued as expectations and a line
// monitor decodes every frame on tx and compares it against the queue.
`timescale 1ns/1ps
module tb_uart_buffered_tx;

  localparam int CLK_HZ = 40;
  localparam int BAUD   = 10;
  localparam int DEPTH  = 8;
  localparam int BC     = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 12;
`else
  localparam int NBITS  = 11;
`endif
  localparam int FRAME_CYC = NBITS * BC;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] data = '0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;

  uart_buffered_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  logic [8:0] sb[$];
  int starts[$];
  int push_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  // Line monitor: a frame begins at the first sampled low level; each bit slot spans BC cycles.
  initial begin : monitor
    logic [8:0]       exp_w;
    logic [NBITS-1:0] bits;
    logic [11:0]      exp_line;
    bit               ok;
    bit               aborted;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        starts.push_back(cyc);
        chk("sb_has_word", 32'(sb.size() > 0), 1);
        exp_w = (sb.size() > 0) ? sb.pop_front() : 9'bx;
        ok = 1'b1;
        aborted = 1'b0;
        bits = '0;
        for (int b = 0; b < NBITS && !aborted; b++) begin
          for (int s = 0; s < BC; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clock);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) bits[b] = tx;
            else if (tx !== bits[b]) ok = 1'b0;
            if (busy !== 1'b1) ok = 1'b0;
          end
        end
        if (!aborted) begin
          exp_line = '0;
          exp_line[9:1] = exp_w;
`ifdef UART_TX_PARITY_EN
          exp_line[10] = ^exp_w;
          exp_line[11] = 1'b1;
`else
          exp_line[10] = 1'b1;
`endif
          chk("frame_steady_busy", 32'(ok), 1);
          chk("frame_bits", 32'(bits), 32'(exp_line[NBITS-1:0]));
          $display("frame at cycle %0d: line 0x%0h expected 0x%0h", starts[$], bits, exp_line[NBITS-1:0]);
        end
      end
    end
  end

  task automatic push(input logic [8:0] w);
    bit acc;
    int t;
    t = 0;
    data = w;
    data_valid = 1'b1;
    do begin
      acc = data_ready;
      @(posedge clock);
      #1;
      t++;
    end while (!acc && t < 2000);
    data_valid = 1'b0;
    if (acc) begin
      sb.push_back(w);
      push_cyc = cyc;
      $display("push 0x%03h accepted at cycle %0d", w, cyc);
    end else begin
      chk("push_accepted_in_time", 0, 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(sb.size() == 0 && busy === 1'b0) && t < budget);
    chk("drain_in_time", 32'(t < budget), 1);
    @(posedge clock);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    int bcnt;
    int base;
    int p0;
    int pa;
    int gaps_bad;

    step(3);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_ready", 32'(data_ready), 1);
    reset = 1'b0;

    bad = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_line_violations", 32'(bad), 0);
    step(1);

    // Single word with push-to-line latency and busy duration.
    push(9'h1A5);
    chk("latency_count_after_push", 32'(fifo_count), 1);
    chk("latency_tx_still_idle", 32'(tx), 1);
    step(1);
    chk("latency_tx_fall", 32'(tx), 0);
    chk("latency_busy_rise", 32'(busy), 1);
    chk("latency_count_after_pop", 32'(fifo_count), 0);
    bcnt = 0;
    repeat (FRAME_CYC + 10) begin
      @(negedge clock);
      if (busy === 1'b1) bcnt++;
    end
    chk("busy_cycles", 32'(bcnt), 32'(FRAME_CYC));
    chk("single_frame_seen", 32'(starts.size()), 1);
    if (starts.size() >= 1) chk("first_pop_latency", 32'(starts[0] - push_cyc), 1);
    wait_idle(4 * FRAME_CYC);

    // Fill the FIFO, then a dropped push at full, then re-present it.
    base = starts.size();
    push(9'h000);
    p0 = push_cyc;
    for (int w = 1; w <= 8; w++) push(9'(w));
    chk("fill_count_peak", 32'(fifo_count), 8);
    chk("fill_ready_low", 32'(data_ready), 0);
    data = 9'h1FF;
    data_valid = 1'b1;
    step(5);
    chk("full_push_dropped", 32'(fifo_count), 8);
    push(9'h1FF);
    chk("refill_count", 32'(fifo_count), 8);
    wait_idle(14 * FRAME_CYC);
    chk("fill_frame_count", 32'(starts.size() - base), 10);
    if (starts.size() >= base + 10) begin
      chk("fill_first_pop", 32'(starts[base] - p0), 1);
      gaps_bad = 0;
      for (int i = 0; i < 9; i++)
        if (starts[base+i+1] - starts[base+i] != FRAME_CYC) gaps_bad++;
      chk("fill_back_to_back", 32'(gaps_bad), 0);
    end

    // Push on the exact edge where the stop bit ends and the queued word pops.
    base = starts.size();
    push(9'($urandom));
    pa = push_cyc;
    step(10);
    push(9'($urandom));
    while (cyc < pa + FRAME_CYC) step(1);
    chk("pre_pop_count", 32'(fifo_count), 1);
    push(9'($urandom));
    chk("simul_push_pop_count", 32'(fifo_count), 1);
    wait_idle(5 * FRAME_CYC);
    chk("simul_frame_count", 32'(starts.size() - base), 3);
    if (starts.size() >= base + 3) begin
      chk("simul_gap_1", 32'(starts[base+1] - starts[base]), 32'(FRAME_CYC));
      chk("simul_gap_2", 32'(starts[base+2] - starts[base+1]), 32'(FRAME_CYC));
    end

    // Random words with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      push(9'($urandom));
      step($urandom_range(0, 2 * FRAME_CYC));
    end
    wait_idle(20 * FRAME_CYC);

    // Reset during data bit 4 with three words queued behind the frame in flight.
    base = starts.size();
    push(9'($urandom));
    pa = push_cyc;
    for (int i = 0; i < 3; i++) push(9'($urandom));
    while (cyc < pa + 1 + 21) step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    sb.delete();
    chk("midreset_tx", 32'(tx), 1);
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_count", 32'(fifo_count), 0);
    chk("midreset_ready", 32'(data_ready), 1);
    step(100);
    chk("no_frames_after_reset", 32'(starts.size() - base), 1);
    push(9'($urandom));
    wait_idle(4 * FRAME_CYC);
    chk("frame_after_reset", 32'(starts.size() - base), 2);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
